// File: rtl/ldl_ram_rd_stream.sv
// ldl_ram_rd_stream
// Read-side master for the simple 2-port RAM. A start command streams len
// words from base upward, with the address wrapping modulo DEPTH. The block
// absorbs the RAM's 1-cycle read latency through a 2-entry output buffer, so
// it sustains 1 word/cycle and handles backpressure without losing words.
//
// Optional feature, macro LDL_RAM_RD_LAST_EN: adds the m_last output, which
// marks the final word of a command and is stored per buffer entry.
//
// Stream handshake: a word transfers on every rising clk edge where
// m_valid && m_ready. While m_valid is high and m_ready is low, m_data
// (and m_last) hold steady. m_valid does not depend on m_ready.
module ldl_ram_rd_stream #(
    parameter int DWIDTH = 8,
    parameter int AWIDTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [AWIDTH-1:0] base,
    input  logic [AWIDTH:0]   len,
    output logic              busy,
    output logic              done,
    output logic              reb,
    output logic [AWIDTH-1:0] addrb,
    input  logic [DWIDTH-1:0] doutb,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DWIDTH-1:0] m_data
`ifdef LDL_RAM_RD_LAST_EN
    ,
    output logic              m_last
`endif
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    localparam logic [AWIDTH-1:0] ONE_A = AWIDTH'(1);
    localparam logic [AWIDTH:0]   ONE_W = (AWIDTH + 1)'(1);

    state_t            state;
    logic [AWIDTH:0]   rd_rem;    // reads still to issue
    logic [AWIDTH:0]   wr_rem;    // words still to hand to the consumer
    logic              inflight;  // a read issued last cycle; doutb is valid now
    logic [1:0]        buf_cnt;
    logic [DWIDTH-1:0] buf0;      // head entry, drives m_data
    logic [DWIDTH-1:0] buf1;
    logic              pop;
    logic              push;
`ifdef LDL_RAM_RD_LAST_EN
    logic              inflight_last;
    logic              last0;
    logic              last1;
`endif

    assign m_valid = (buf_cnt != 2'd0);
    assign m_data  = buf0;
    assign pop     = m_valid & m_ready;
    assign push    = inflight;
`ifdef LDL_RAM_RD_LAST_EN
    assign m_last  = last0;
`endif

    // Issue a read only if the word it returns is guaranteed a buffer slot.
    // The pop is added to the right-hand side so the arithmetic cannot go negative.
    always_comb begin
        reb = 1'b0;
        if ((state == RUN) && (rd_rem != '0) &&
            (({1'b0, buf_cnt} + {2'b00, inflight}) < (3'd2 + {2'b00, pop})))
            reb = 1'b1;
    end

    // Command FSM: command acceptance, read address/count, completion and done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            addrb         <= '0;
            rd_rem        <= '0;
            wr_rem        <= '0;
            inflight      <= 1'b0;
`ifdef LDL_RAM_RD_LAST_EN
            inflight_last <= 1'b0;
`endif
        end else begin
            done     <= 1'b0;
            inflight <= reb;
`ifdef LDL_RAM_RD_LAST_EN
            inflight_last <= reb && (rd_rem == ONE_W);
`endif
            if (reb) begin
                addrb  <= addrb + ONE_A;
                rd_rem <= rd_rem - ONE_W;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        if (len == '0) begin
                            done <= 1'b1;
                        end else begin
                            state  <= RUN;
                            busy   <= 1'b1;
                            addrb  <= base;
                            rd_rem <= len;
                            wr_rem <= len;
                        end
                    end
                end
                RUN: begin
                    if (pop) begin
                        wr_rem <= wr_rem - ONE_W;
                        if (wr_rem == ONE_W) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Two-entry output buffer kept as a shift pair: buf0 is always the head.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_cnt <= 2'd0;
            buf0    <= '0;
            buf1    <= '0;
`ifdef LDL_RAM_RD_LAST_EN
            last0   <= 1'b0;
            last1   <= 1'b0;
`endif
        end else begin
            case ({push, pop})
                2'b10: begin
                    buf_cnt <= buf_cnt + 2'd1;
                    if (buf_cnt == 2'd0) begin
                        buf0 <= doutb;
`ifdef LDL_RAM_RD_LAST_EN
                        last0 <= inflight_last;
`endif
                    end else begin
                        buf1 <= doutb;
`ifdef LDL_RAM_RD_LAST_EN
                        last1 <= inflight_last;
`endif
                    end
                end
                2'b01: begin
                    buf_cnt <= buf_cnt - 2'd1;
                    buf0    <= buf1;
`ifdef LDL_RAM_RD_LAST_EN
                    last0   <= last1;
`endif
                end
                2'b11: begin
                    // Count unchanged; the new word goes behind whatever remains.
                    if (buf_cnt == 2'd1) begin
                        buf0 <= doutb;
`ifdef LDL_RAM_RD_LAST_EN
                        last0 <= inflight_last;
`endif
                    end else begin
                        buf0 <= buf1;
                        buf1 <= doutb;
`ifdef LDL_RAM_RD_LAST_EN
                        last0 <= last1;
                        last1 <= inflight_last;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ldl_ram_rd_stream.sv
// Testbench for ldl_ram_rd_stream with a registered-read RAM model
// preloaded with mem[i] = 8'hA0 + i.
module tb_ldl_ram_rd_stream;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] base = '0;
    logic [4:0] len = '0;
    logic       busy;
    logic       done;
    logic       reb;
    logic [3:0] addrb;
    logic [7:0] doutb = '0;
    logic       m_valid;
    logic       m_ready = 1'b0;
    logic [7:0] m_data;
`ifdef LDL_RAM_RD_LAST_EN
    logic       m_last;
`endif

    int checks = 0;
    int failures = 0;

    logic [7:0] mem [16];

    always #5 clk = ~clk;

    // RAM read port: data registered one cycle after reb
    always @(posedge clk) if (reb) doutb <= mem[addrb];

    ldl_ram_rd_stream #(.DWIDTH(8), .AWIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base(base), .len(len),
        .busy(busy), .done(done), .reb(reb), .addrb(addrb), .doutb(doutb),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data)
`ifdef LDL_RAM_RD_LAST_EN
        , .m_last(m_last)
`endif
    );

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, reb, addrb, m_valid, m_data} !== 16'h0) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=0", {busy, done, reb, addrb, m_valid, m_data});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Runs one command and checks addresses, data order, occupancy, stall
    // stability and (when timing=1) exact cycle positions relative to the
    // start edge. bp selects the m_ready pattern 1,0,0,1,0,1; ign fires an
    // extra start (base=7) while busy.
    task automatic run_cmd(input logic [3:0] b, input logic [4:0] n,
                           input bit bp, input bit ign, input bit timing);
        int got = 0, issued = 0, dones = 0, occ = 0, tail = 0;
        logic r1 = 1'b0, r2 = 1'b0, stalled = 1'b0, fin = 1'b0;
        logic [7:0] held = '0;
        logic [7:0] exp_d;
        logic [3:0] exp_addr, a4;
        bit pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        exp_addr = b;
        @(negedge clk);
        start = 1'b1; base = b; len = n; m_ready = 1'b1;
        for (int c = 1; c <= 300 && tail < 3; c++) begin
            @(negedge clk);
            start = (ign && c == 2);
            if (ign && c == 2) begin base = 4'd7; len = 5'd5; end
            m_ready = bp ? pat[c % 6] : 1'b1;
            #1;
            occ = occ + int'(r2);
            checks++;
            if (occ > 2 || m_valid !== (occ > 0)) begin
                failures++;
                $display("FAIL occupancy c=%0d m_valid=%b model_occ=%0d", c, m_valid, occ);
            end
            if (stalled) begin
                checks++;
                if (m_valid !== 1'b1 || m_data !== held) begin
                    failures++;
                    $display("FAIL stall_stable c=%0d got v=%b d=%h exp v=1 d=%h", c, m_valid, m_data, held);
                end
            end
            if (fin) begin
                checks++;
                if (reb !== 1'b0 || done !== 1'b0 || m_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL idle_after_done reb=%b done=%b m_valid=%b exp 0", reb, done, m_valid);
                end
                tail++;
            end
            if (reb === 1'b1) begin
                checks++;
                if (addrb !== exp_addr || (timing && c != issued + 1) || issued >= int'(n)) begin
                    failures++;
                    $display("FAIL read_issue c=%0d addrb=%h exp=%h idx=%0d", c, addrb, exp_addr, issued);
                end
                exp_addr = exp_addr + 4'd1;
                issued++;
            end
            if (done === 1'b1) begin
                dones++;
                checks++;
                if (busy !== 1'b0 || (timing && c != int'(n) + 3)) begin
                    failures++;
                    $display("FAIL done_timing c=%0d busy=%b exp c=%0d busy=0", c, busy, int'(n) + 3);
                end
                fin = 1'b1;
            end else if (!fin && timing) begin
                checks++;
                if (busy !== 1'b1) begin
                    failures++;
                    $display("FAIL busy c=%0d got=%b exp=1", c, busy);
                end
            end
            if (m_valid === 1'b1 && m_ready === 1'b1) begin
                a4 = b + got[3:0];
                exp_d = 8'hA0 + {4'h0, a4};
                checks++;
                if (m_data !== exp_d || (timing && c != 3 + got)) begin
                    failures++;
                    $display("FAIL stream_data c=%0d got=%h exp=%h at c=%0d", c, m_data, exp_d, 3 + got);
                end
`ifdef LDL_RAM_RD_LAST_EN
                checks++;
                if (m_last !== (got == int'(n) - 1)) begin
                    failures++;
                    $display("FAIL m_last word=%0d got=%b", got, m_last);
                end
`endif
                got++;
                occ--;
            end
            stalled = m_valid && !m_ready;
            held = m_data;
            r2 = r1;
            r1 = reb;
        end
        m_ready = 1'b1;
        checks++;
        if (!fin || got != int'(n) || issued != int'(n) || dones != 1) begin
            failures++;
            $display("FAIL cmd_totals base=%h got=%0d issued=%0d dones=%0d exp=%0d/%0d/1",
                     b, got, issued, dones, n, n);
        end
    endtask

    task automatic test_len_zero();
        @(negedge clk);
        start = 1'b1; base = 4'd5; len = 5'd0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            checks++;
            if (reb !== 1'b0 || busy !== 1'b0 || done !== (c == 1)) begin
                failures++;
                $display("FAIL len_zero c=%0d reb=%b busy=%b done=%b exp 0,0,%b", c, reb, busy, done, c == 1);
            end
        end
    endtask

    task automatic test_reset_mid();
        int got = 0;
        @(negedge clk);
        start = 1'b1; base = 4'd0; len = 5'd5; m_ready = 1'b1;
        for (int c = 1; c <= 20 && got < 2; c++) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            if (m_valid === 1'b1) got++;
        end
        checks++;
        if (got != 2) begin
            failures++;
            $display("FAIL reset_mid_setup got=%0d exp=2", got);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, reb, addrb, m_valid, m_data} !== 16'h0) begin
            failures++;
            $display("FAIL reset_async got=%h exp=0", {busy, done, reb, addrb, m_valid, m_data});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (m_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_release m_valid=%b busy=%b exp 0", m_valid, busy);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'hA0 + 8'(i);
        test_reset();
        run_cmd(4'd2, 5'd4, 1'b0, 1'b0, 1'b1);   // basic
        run_cmd(4'd14, 5'd4, 1'b0, 1'b0, 1'b1);  // wrap-around
        run_cmd(4'd0, 5'd6, 1'b1, 1'b0, 1'b0);   // backpressure
        test_len_zero();
        run_cmd(4'd9, 5'd16, 1'b0, 1'b0, 1'b1);  // full depth
        run_cmd(4'd0, 5'd3, 1'b0, 1'b1, 1'b1);   // ignored start
        test_reset_mid();
        run_cmd(4'd3, 5'd2, 1'b0, 1'b0, 1'b1);   // after abort
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ldl_ram_rd_stream.md
Name: ldl_ram_rd_stream

Overview:
Read-side master for the team's simple 2-port RAM. On a start command it issues sequential read requests (reb/addrb) from a base address for a given length. It absorbs the RAM's 1-cycle registered read latency and presents the words on a valid/ready stream with full throughput and lossless backpressure. It sits between the RAM read port and any downstream consumer (DMA, serializer, packet TX).

Parameters:
DWIDTH, 8, data word width; must match the RAM.
AWIDTH, 4, address width; DEPTH = 2**AWIDTH.

Ports:
clk  input  1  single clock; drives the RAM read port too
rst_n  input  1  asynchronous active-low reset
start  input  1  command strobe; accepted only when busy=0
base  input  AWIDTH  first read address, sampled on accepted start
len  input  AWIDTH+1  word count 0..DEPTH, sampled on accepted start
busy  output  1  high while a command is in progress
done  output  1  1-cycle pulse when a command completes
reb  output  1  RAM read enable
addrb  output  AWIDTH  RAM read address
doutb  input  DWIDTH  RAM read data; valid the cycle after reb
m_valid  output  1  stream data valid
m_ready  input  1  stream consumer ready
m_data  output  DWIDTH  stream data

Behaviour:
- Reset (async assert, sync release): busy=0, done=0, reb=0, addrb=0, m_valid=0, m_data=0, buffer empty, no read in flight, state IDLE.
- FSM: IDLE -> RUN on start with len>0. RUN -> IDLE on the handshake (m_valid&m_ready) of the final word. IDLE -> IDLE on start with len=0, with done pulsed next cycle and no reb issued.
- start while busy=1 is ignored and has no effect on the current command.
- busy rises the cycle after an accepted start. busy falls in the cycle after the final handshake; done pulses in that same cycle.
- Output buffer: 2 entries. m_valid is high when the buffer is non-empty. m_data is the head entry, driven from a register.
- Read issue rule is combinational from registered state: reb=1 when in RUN, reads_remaining>0, and (buf_cnt + inflight - pop) < 2. Here inflight = reb of the previous cycle, and pop = m_valid&m_ready.
- Under this rule the buffer never overflows and doutb is never dropped.
- Captured word: the cycle after reb, doutb is written into the buffer.
- addrb starts at base and increments by 1 after each issued read. It wraps modulo DEPTH (for example 15 -> 0). addrb holds its value when reb=0.
- Latency: start sampled at edge k. First reb is in cycle k+1. First m_valid is in cycle k+3.
- With m_ready held at 1, the block sustains 1 word/cycle. A len=N command completes with done at cycle k+N+3.
- Backpressure: m_data and m_valid stay stable while m_valid&!m_ready. Reads stall per the issue rule.
- Simultaneous push and pop: the buffer count is unchanged and order is preserved (FIFO order).
- len=DEPTH reads every location exactly once, starting at base.
- Reset mid-command aborts immediately: all outputs return to reset values, and any in-flight read data is discarded.

Optional Feature:
Macro LDL_RAM_RD_LAST_EN.
- Defined: adds output port m_last (1 bit, reset 0). m_last is asserted together with m_valid on the final word of a command and is stable under backpressure. The last flag is stored per buffer entry.
- Not defined: the m_last port and its storage are absent. All other behaviour is identical.

Test Plan:
- RAM preloaded with mem[i]=8'hA0+i. start, base=2, len=4, m_ready=1 -> addrb sequence 2,3,4,5 in consecutive cycles; m_data A2,A3,A4,A5 on consecutive cycles starting k+3; done at k+7; with macro, m_last only on A5.
- Wrap-around: base=14, len=4 -> addrb 14,15,0,1; m_data AE,AF,A0,A1.
- Backpressure: base=0, len=6, m_ready toggles 1,0,0,1,0,1... -> all six words A0..A5 delivered in order, no duplicates, m_data stable while stalled; buffer never exceeds 2 entries (assertion).
- len=0 start -> reb never asserted, busy stays 0, done pulses once next cycle. len=16, base=9 -> 16 words A9..AF, A0..A8.
- Ignored start: second start with base=7 issued while busy during a base=0, len=3 command -> only A0,A1,A2 delivered, a single done pulse.
- Reset: assert rst_n=0 after 2 of 5 words are delivered -> outputs go to 0 asynchronously. After release, start base=3, len=2 delivers A3,A4 with no stale data.
